agu_arbiter: RTL
================

Name: agu_arbiter

Overview:
Shares the single address-generation unit between two requesters: the load/store unit (LSU) and the branch/jump unit (BRU). It arbitrates requests with a valid/ready handshake and drives the AGU combinationally. It captures the AGU result into one response register, tagged with the requester ID and with the alignment exception qualified. It sits between the EX-stage requesters and the AGU instance.

Parameters:
ADDR_W, 32, address width (AGU input and result width)
OFF_W, 26, offset width (AGU offset input width)
PRIO_MODE, 0, 0 = round-robin between LSU and BRU; 1 = fixed priority, BRU always wins

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_lsu_valid  in  1  LSU request valid
i_lsu_opcode  in  3  LSU AGU mode
i_lsu_addr  in  ADDR_W  LSU base address (RS value)
i_lsu_offset  in  OFF_W  LSU offset
o_lsu_ready  out  1  LSU request accepted this cycle
i_bru_valid  in  1  BRU request valid
i_bru_opcode  in  3  BRU AGU mode
i_bru_addr  in  ADDR_W  BRU base (PC+4 or RS)
i_bru_offset  in  OFF_W  BRU offset / jump index
o_bru_ready  out  1  BRU request accepted this cycle
o_agu_opcode  out  3  to AGU
o_agu_addr  out  ADDR_W  to AGU
o_agu_offset  out  OFF_W  to AGU
i_agu_eff_addr  in  ADDR_W  from AGU
i_agu_exception  in  2  from AGU (low two address bits)
o_rsp_valid  out  1  response register holds a result
o_rsp_id  out  1  0 = LSU, 1 = BRU
o_rsp_addr  out  ADDR_W  effective address
o_rsp_exc  out  1  misaligned-word exception
o_rsp_err  out  1  illegal opcode (opcode[2] = 1)
i_rsp_ready  in  1  consumer takes the response

Behaviour:
- Clock i_clk. Reset i_reset is asynchronous and active-high. On reset, all response outputs are 0, the round-robin pointer points to LSU, and the FSM is in EMPTY.
- FSM:
  - States: EMPTY (no response held) and FULL (response held).
  - Slot free = EMPTY, or (FULL and i_rsp_ready).
  - Next state: FULL if a request is accepted, else EMPTY if the response drains, else hold.
- Arbitration (combinational):
  - Only one request is granted per cycle, and only when the slot is free.
  - PRIO_MODE=0: if both are valid, grant the requester the pointer names. After each accept, the pointer moves to the other requester. A single valid requester is always granted.
  - PRIO_MODE=1: BRU wins whenever valid.
- o_xxx_ready = grant for that requester. A request is accepted when valid && ready.
- Requesters hold all request fields stable until accepted.
- AGU drive:
  - o_agu_* mux the granted request's fields.
  - With no grant, o_agu_* hold the last granted values, so the AGU does not toggle.
- Capture on accept, latency 1 cycle (response visible on the cycle after the accept edge):
  - o_rsp_addr = i_agu_eff_addr, o_rsp_id = granted ID.
  - o_rsp_exc = |i_agu_exception, only for opcodes 000 and 001. Forced to 0 for 010 and 011, because the AGU does not update its exception output in those modes.
  - o_rsp_err = opcode[2]. For an illegal opcode, o_rsp_addr = 0 and o_rsp_exc = 0, and the request is still accepted (no deadlock).
- Back-to-back: FULL && i_rsp_ready && new request → drain and capture on the same edge. o_rsp_valid stays 1, giving full throughput.
- FULL && !i_rsp_ready: both ready outputs are 0 and the response holds stable.
- A valid that drops before it is accepted is legal (pipeline flush). Nothing is captured for it.
- Reset mid-operation discards a held response. Requesters must re-present their requests.
- Address arithmetic is performed solely by the AGU. The arbiter does no arithmetic.

Decomposition:
- Shared package (agu_pkg):
  - AGU opcode constants: AGU_RS=3'b000, AGU_BASE_OFF=3'b001, AGU_PC_REL=3'b010, AGU_JUMP=3'b011.
  - Requester ID constants: REQ_LSU=0, REQ_BRU=1.
  - ADDR_W and OFF_W defaults.
- Sub-module: one natural sub-module, rr_arb2 (2-way round-robin grant with pointer register), selectable by PRIO_MODE. The FSM and response register stay in the top module.

Test Plan:
- LSU only, opcode 001, addr 0x1000_0000, offset 0x000FFFC → LSU ready the same cycle. Next cycle rsp_valid=1, id=0, addr=0x0FFF_FFFC, exc=0.
- BRU only, opcode 011, addr 0xA000_0000, offset 0x0000100 → addr=0xA000_0400, exc=0. Also opcode 010, addr 0x0040_0010, offset 0x000FFFF → addr=0x0040_000C, exc=0.
- Both valid every cycle, i_rsp_ready=1, PRIO_MODE=0 → grants alternate LSU, BRU, LSU, BRU, one response per cycle. PRIO_MODE=1 → BRU is granted every cycle and LSU is starved.
- LSU opcode 001, addr 0x0000_1001, offset 0 → exc=1. Follow with BRU opcode 010 producing a result with low bits 00 → exc=0 (no stale exception).
- i_rsp_ready=0 for 3 cycles while both are valid → both ready=0 and the response is stable. When ready rises, drain and capture on the same edge.
- Opcode 3'b100 → accepted, err=1, addr=0. Assert i_reset mid-FULL → rsp_valid=0 asynchronously and the pointer returns to LSU.

Source files
------------

// File: rtl/agu_pkg.sv
// Shared definitions for the AGU arbiter: opcode encodings, requester IDs,
// default widths, response FSM states and the exception qualifier.
package agu_pkg;

    localparam int AGU_ADDR_W = 32;
    localparam int AGU_OFF_W  = 26;

    localparam logic [2:0] AGU_RS       = 3'b000;
    localparam logic [2:0] AGU_BASE_OFF = 3'b001;
    localparam logic [2:0] AGU_PC_REL   = 3'b010;
    localparam logic [2:0] AGU_JUMP     = 3'b011;

    localparam logic REQ_LSU = 1'b0;
    localparam logic REQ_BRU = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

    // The AGU only refreshes its exception bits in the RS and base+offset
    // modes; in every other mode they are stale and must be masked.
    function automatic logic qualify_exc(input logic [2:0] opcode,
                                         input logic [1:0] agu_exc);
        logic exc;
        case (opcode)
            AGU_RS, AGU_BASE_OFF: exc = |agu_exc;
            AGU_PC_REL, AGU_JUMP: exc = 1'b0;
            default:              exc = 1'b0;
        endcase
        return exc;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin with a pointer register, or fixed priority
// to the BRU side when PRIO_MODE is non-zero. Bit 0 = LSU, bit 1 = BRU.
module rr_arb2
    import agu_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    localparam bit FIXED_PRIO = (PRIO_MODE != 32'sd0);

    logic ptr_r;

    // Grant at most one requester, and only while the downstream slot is free.
    always_comb begin
        grant = 2'b00;
        if (!enable) begin
            grant = 2'b00;
        end else if (req == 2'b11) begin
            if (FIXED_PRIO) begin
                grant = 2'b10;
            end else if (ptr_r == REQ_BRU) begin
                grant = 2'b10;
            end else begin
                grant = 2'b01;
            end
        end else begin
            grant = req;
        end
    end

    // Pointer moves to the requester that was not just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= REQ_LSU;
        end else if (grant[REQ_LSU]) begin
            ptr_r <= REQ_BRU;
        end else if (grant[REQ_BRU]) begin
            ptr_r <= REQ_LSU;
        end
    end

endmodule

// File: rtl/agu_arbiter.sv
// Shares one AGU between the LSU and BRU. Grants one request per cycle,
// drives the AGU combinationally, and captures the tagged result into a
// single response slot that supports back-to-back drain and refill.
module agu_arbiter
    import agu_pkg::*;
#(
    parameter int ADDR_W    = AGU_ADDR_W,
    parameter int OFF_W     = AGU_OFF_W,
    parameter int PRIO_MODE = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_lsu_valid,
    input  logic [2:0]        i_lsu_opcode,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic [OFF_W-1:0]  i_lsu_offset,
    output logic              o_lsu_ready,
    input  logic              i_bru_valid,
    input  logic [2:0]        i_bru_opcode,
    input  logic [ADDR_W-1:0] i_bru_addr,
    input  logic [OFF_W-1:0]  i_bru_offset,
    output logic              o_bru_ready,
    output logic [2:0]        o_agu_opcode,
    output logic [ADDR_W-1:0] o_agu_addr,
    output logic [OFF_W-1:0]  o_agu_offset,
    input  logic [ADDR_W-1:0] i_agu_eff_addr,
    input  logic [1:0]        i_agu_exception,
    output logic              o_rsp_valid,
    output logic              o_rsp_id,
    output logic [ADDR_W-1:0] o_rsp_addr,
    output logic              o_rsp_exc,
    output logic              o_rsp_err,
    input  logic              i_rsp_ready
);

    rsp_state_e        state_r;
    rsp_state_e        state_nxt_s;
    logic              slot_free_s;
    logic [1:0]        grant_s;
    logic              accept_s;

    logic [2:0]        sel_opcode_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [OFF_W-1:0]  sel_offset_s;
    logic [2:0]        last_opcode_r;
    logic [ADDR_W-1:0] last_addr_r;
    logic [OFF_W-1:0]  last_offset_r;

    logic              rsp_id_r;
    logic [ADDR_W-1:0] rsp_addr_r;
    logic              rsp_exc_r;
    logic              rsp_err_r;

    rr_arb2 #(
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .clk    (i_clk),
        .rst    (i_reset),
        .req    ({i_bru_valid, i_lsu_valid}),
        .enable (slot_free_s),
        .grant  (grant_s)
    );

    assign accept_s    = |grant_s;
    assign o_lsu_ready = grant_s[REQ_LSU];
    assign o_bru_ready = grant_s[REQ_BRU];

    // Slot can take a new result when empty or when the held one drains now.
    always_comb begin
        slot_free_s = 1'b0;
        case (state_r)
            ST_EMPTY: slot_free_s = 1'b1;
            ST_FULL:  slot_free_s = i_rsp_ready;
            default:  slot_free_s = 1'b0;
        endcase
    end

    // Next state: refill wins over drain, so back-to-back stays FULL.
    always_comb begin
        state_nxt_s = state_r;
        if (accept_s) begin
            state_nxt_s = ST_FULL;
        end else if ((state_r == ST_FULL) && i_rsp_ready) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Response FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // AGU input mux; without a grant the last granted fields are replayed
    // so the AGU inputs stay quiet.
    always_comb begin
        sel_opcode_s = last_opcode_r;
        sel_addr_s   = last_addr_r;
        sel_offset_s = last_offset_r;
        if (grant_s[REQ_BRU]) begin
            sel_opcode_s = i_bru_opcode;
            sel_addr_s   = i_bru_addr;
            sel_offset_s = i_bru_offset;
        end else if (grant_s[REQ_LSU]) begin
            sel_opcode_s = i_lsu_opcode;
            sel_addr_s   = i_lsu_addr;
            sel_offset_s = i_lsu_offset;
        end else begin
            sel_opcode_s = last_opcode_r;
            sel_addr_s   = last_addr_r;
            sel_offset_s = last_offset_r;
        end
    end

    assign o_agu_opcode = sel_opcode_s;
    assign o_agu_addr   = sel_addr_s;
    assign o_agu_offset = sel_offset_s;

    // Remember the most recently granted AGU inputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            last_opcode_r <= AGU_RS;
            last_addr_r   <= {ADDR_W{1'b0}};
            last_offset_r <= {OFF_W{1'b0}};
        end else if (accept_s) begin
            last_opcode_r <= sel_opcode_s;
            last_addr_r   <= sel_addr_s;
            last_offset_r <= sel_offset_s;
        end
    end

    // Capture the AGU result on accept; illegal opcodes report err with a
    // zeroed address so the requester is never left stuck.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rsp_id_r   <= REQ_LSU;
            rsp_addr_r <= {ADDR_W{1'b0}};
            rsp_exc_r  <= 1'b0;
            rsp_err_r  <= 1'b0;
        end else if (accept_s) begin
            rsp_id_r   <= grant_s[REQ_BRU];
            rsp_err_r  <= sel_opcode_s[2];
            rsp_exc_r  <= qualify_exc(sel_opcode_s, i_agu_exception);
            rsp_addr_r <= sel_opcode_s[2] ? {ADDR_W{1'b0}} : i_agu_eff_addr;
        end
    end

    assign o_rsp_valid = (state_r == ST_FULL);
    assign o_rsp_id    = rsp_id_r;
    assign o_rsp_addr  = rsp_addr_r;
    assign o_rsp_exc   = rsp_exc_r;
    assign o_rsp_err   = rsp_err_r;

endmodule
